// File: rtl/bus_arbiter_if.sv
// Bus request/grant bundle between requesters (master side) and the arbiter (slave side).
interface bus_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       enable;
    logic       busy;

    modport master (
        output req,
        input  grant,
        input  sel,
        input  enable,
        input  busy
    );

    modport slave (
        input  req,
        output grant,
        output sel,
        output enable,
        output busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with a bounded hold time and a one-cycle
// undriven turnaround between owners; every output comes straight from a flop.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       enable_q, enable_d;
    logic       busy_q, busy_d;
    logic [3:0] hold_q, hold_d;
    logic [1:0] last_q, last_d;
    logic [1:0] rst_sync_q;

    logic       run;
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       others;

    // Assertion is immediate; release is held off two edges so the FSM starts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    // Searching last_q+1..last_q+4 makes the previous owner the lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        enable_d = enable_q;
        busy_d   = busy_q;
        hold_d   = hold_q;
        last_d   = last_q;
        others   = |(bus.req & ~grant_q);

        case (state_q)
            IDLE, TURN: begin
                if (win_found) begin
                    state_d  = OWN;
                    grant_d  = 4'b0001 << win_idx;
                    sel_d    = win_idx;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                    hold_d   = 4'd1;
                    last_d   = win_idx;
                end else begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    enable_d = 1'b0;
                    busy_d   = 1'b0;
                    hold_d   = '0;
                end
            end
            OWN: begin
                if (!bus.req[sel_q] || (hold_q == HOLD_MAX && others)) begin
                    state_d  = TURN;
                    grant_d  = '0;
                    enable_d = 1'b0;
                    busy_d   = 1'b1;
                    hold_d   = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                enable_d = 1'b0;
                busy_d   = 1'b0;
                hold_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            hold_q   <= '0;
            last_q   <= 2'd3;
        end else if (run) begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.sel    = sel_q;
    assign bus.enable = enable_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues per-edge expectations, a monitor checks them.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_if bus ();

    bus_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       enable;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    logic [3:0] prev_grant = '0;

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b at %0t", name, act, want, $time);
        end
    endfunction

    // Monitor: one look per cycle, shortly after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("onehot", 8'($countones(bus.grant) <= 1), 8'd1);
            check("en_eq_or_grant", 8'(bus.enable), 8'(|bus.grant));
            if (prev_grant != 4'b0 && bus.grant != 4'b0)
                check("handover_gap", 8'(bus.grant), 8'(prev_grant));
            prev_grant = bus.grant;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant",  8'(bus.grant),  8'(e.grant));
                check("sel",    8'(bus.sel),    8'(e.sel));
                check("enable", 8'(bus.enable), 8'(e.enable));
                check("busy",   8'(bus.busy),   8'(e.busy));
            end
        end
    end

    function automatic void push_exp(input logic [3:0] g, input logic [1:0] s, input logic b);
        exp_t e;
        e.grant  = g;
        e.sel    = s;
        e.enable = |g;
        e.busy   = b;
        exp_q.push_back(e);
    endfunction

    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s, input logic b);
        @(negedge clk);
        bus.req = r;
        push_exp(g, s, b);
    endtask

    // Async assert with immediate output check; the two edges after release must stay idle.
    task automatic do_reset(input logic [3:0] r);
        @(negedge clk);
        bus.req = r;
        rst_n = 1'b0;
        #1;
        check("rst_grant",  8'(bus.grant),  8'd0);
        check("rst_sel",    8'(bus.sel),    8'd0);
        check("rst_enable", 8'(bus.enable), 8'd0);
        check("rst_busy",   8'(bus.busy),   8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_exp(4'b0000, 2'd0, 1'b0);
        step(r, 4'b0000, 2'd0, 1'b0);
    endtask

    initial begin
        bus.req = '0;

        // Request-to-grant latency and simple handoff
        do_reset(4'b0000);
        step(4'b0101, 4'b0001, 2'd0, 1'b1);
        step(4'b0100, 4'b0000, 2'd0, 1'b1);
        step(4'b0100, 4'b0100, 2'd2, 1'b1);
        step(4'b0000, 4'b0000, 2'd2, 1'b1);
        step(4'b0000, 4'b0000, 2'd2, 1'b0);

        // Hold limit forces release to a pending requester
        do_reset(4'b0000);
        repeat (8) step(4'b0101, 4'b0001, 2'd0, 1'b1);
        step(4'b0101, 4'b0000, 2'd0, 1'b1);
        step(4'b0101, 4'b0100, 2'd2, 1'b1);
        step(4'b0000, 4'b0000, 2'd2, 1'b1);
        step(4'b0000, 4'b0000, 2'd2, 1'b0);

        // Full rotation, each owner dropping after two cycles
        do_reset(4'b0000);
        step(4'b1111, 4'b0001, 2'd0, 1'b1);
        step(4'b1111, 4'b0001, 2'd0, 1'b1);
        step(4'b1110, 4'b0000, 2'd0, 1'b1);
        step(4'b1110, 4'b0010, 2'd1, 1'b1);
        step(4'b1110, 4'b0010, 2'd1, 1'b1);
        step(4'b1100, 4'b0000, 2'd1, 1'b1);
        step(4'b1100, 4'b0100, 2'd2, 1'b1);
        step(4'b1100, 4'b0100, 2'd2, 1'b1);
        step(4'b1000, 4'b0000, 2'd2, 1'b1);
        step(4'b1001, 4'b1000, 2'd3, 1'b1);
        step(4'b1001, 4'b1000, 2'd3, 1'b1);
        step(4'b0001, 4'b0000, 2'd3, 1'b1);
        step(4'b0001, 4'b0001, 2'd0, 1'b1);
        step(4'b0000, 4'b0000, 2'd0, 1'b1);
        step(4'b0000, 4'b0000, 2'd0, 1'b0);

        // Lone requester keeps the bus; saturated counter releases at once when a rival appears
        do_reset(4'b0000);
        repeat (19) step(4'b1000, 4'b1000, 2'd3, 1'b1);
        step(4'b1001, 4'b0000, 2'd3, 1'b1);
        step(4'b1001, 4'b0001, 2'd0, 1'b1);
        step(4'b0000, 4'b0000, 2'd0, 1'b1);
        step(4'b0000, 4'b0000, 2'd0, 1'b0);

        // Reset mid-ownership, then re-arbitration after synchronised release
        do_reset(4'b0000);
        step(4'b0010, 4'b0010, 2'd1, 1'b1);
        step(4'b0010, 4'b0010, 2'd1, 1'b1);
        do_reset(4'b0010);
        step(4'b0010, 4'b0010, 2'd1, 1'b1);
        step(4'b0000, 4'b0000, 2'd1, 1'b1);
        step(4'b0000, 4'b0000, 2'd1, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, max consecutive cycles one requester owns the bus while another requester is pending; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  bus request, bit k from requester k; level-sensitive.
REQ-005 Port: grant  output  4  one-hot grant; bit k high means requester k owns the bus.
REQ-006 Port: sel  output  2  index of current or most recent owner; drives the tri-state buffer select.
REQ-007 Port: enable  output  1  tri-state buffer enable; high only while a grant is active.
REQ-008 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-009 States SHALL be IDLE, OWN and TURN, encoded in a registered state machine.
REQ-010 All outputs SHALL be registered or decoded from registered state only; no combinational path from req to any output.
REQ-011 Round-robin pointer last_owner (2 bits): search order is last_owner+1, +2, +3, +4, mod 4; first asserted req wins.
REQ-012 IDLE: grant=0000, enable=0; any req bit high at an edge -> OWN next cycle with the winner granted (1-cycle request-to-grant latency).
REQ-013 On entry to OWN: grant=one-hot(winner), sel=winner, enable=1, last_owner<=winner, hold counter<=1.
REQ-014 OWN: hold counter increments each cycle and saturates at MAX_HOLD.
REQ-015 OWN release, condition A: req[owner] sampled low.
REQ-016 OWN release, condition B: hold counter == MAX_HOLD and any other req bit high.
REQ-017 If A or B holds, next state SHALL be TURN; simultaneous A and B SHALL cause one release only.
REQ-018 Owner at MAX_HOLD with no other requester pending SHALL stay in OWN indefinitely with counter saturated.
REQ-019 TURN lasts exactly one cycle: grant=0000, enable=0, sel holds previous owner; bus is guaranteed undriven between owners.
REQ-020 TURN exit: any req high -> OWN with round-robin winner (previous owner is lowest priority); else -> IDLE.
REQ-021 A released owner still requesting SHALL be re-granted from TURN only if no other req bit is high.
REQ-022 grant SHALL never have more than one bit set.
REQ-023 enable SHALL equal OR of grant in every cycle.

Reset
REQ-024 rst_n low SHALL immediately, without a clock edge, force: state=IDLE, grant=0000, sel=00, enable=0, busy=0, hold counter=0, last_owner=3 (requester 0 highest priority after reset).
REQ-025 Reset asserted mid-OWN SHALL drop enable asynchronously; after release, arbitration resumes from IDLE per REQ-012.
REQ-026 Release of rst_n SHALL be synchronised so that the first state change occurs no earlier than the second rising edge after deassertion.

Verification
REQ-027 After reset, req=0101 at edge 0 -> edge 1: grant=0001, sel=00, enable=1, busy=1.
REQ-028 req[0] held, req[2] high, MAX_HOLD=8 -> grant=0001 for 8 cycles, one TURN cycle (enable=0, sel=00), then grant=0100, sel=10.
REQ-029 req=1111 held with each owner dropping req after 2 cycles -> grant sequence 0001,0010,0100,1000,0001, each pair separated by one enable=0 cycle.
REQ-030 Single requester req=1000 held for 20 cycles -> grant=1000 continuous from cycle 1, no TURN inserted, counter saturated at 8.
REQ-031 rst_n pulsed low mid-OWN (grant=0010) -> enable=0 and grant=0000 before the next edge; after release with req=0010 -> grant=0010 again.
REQ-032 Every cycle of every test: grant one-hot or zero, enable==|grant, no owner-to-owner change without an intervening enable=0 cycle.
